// File: rtl/temp_bcd_formatter.sv
// Serial binary-to-BCD converter (double dabble) for an 8-bit temperature.
// It presents hundreds/tens/ones digits with optional leading-zero blanking and a unit tag.
module temp_bcd_formatter #(
  parameter int BLANK_LEADING = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin_in,
  input  logic       unit_in,
  output logic       ready,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       unit_out
);

  // Handshake: start is accepted only on an edge where ready=1 (state IDLE).
  // done is a one-cycle pulse. The digit outputs and unit_out are valid from that
  // pulse onward and hold until the next pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] dd_q, dd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        unit_cap_q, unit_cap_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [3:0]  hundreds_q, hundreds_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  ones_q, ones_d;
  logic        unit_out_q, unit_out_d;

  logic [3:0]  bcd_h, bcd_t, bcd_o;
  logic        blank_h, blank_t;

  // Each step adds 3 to every BCD nibble that is >= 5, then shifts {bcd, bin} left by one.
  function automatic logic [19:0] dabble(input logic [19:0] v);
    logic [19:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  always_comb begin
    bcd_h   = dd_q[19:16];
    bcd_t   = dd_q[15:12];
    bcd_o   = dd_q[11:8];
    blank_h = (BLANK_LEADING != 0) && (bcd_h == 4'd0);
    blank_t = blank_h && (bcd_t == 4'd0);
  end

  always_comb begin
    state_d    = state_q;
    dd_d       = dd_q;
    cnt_d      = cnt_q;
    unit_cap_d = unit_cap_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    hundreds_d = hundreds_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    unit_out_d = unit_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dd_d       = {12'd0, bin_in};
          cnt_d      = 3'd0;
          unit_cap_d = unit_in;
          ready_d    = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        dd_d  = dabble(dd_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        hundreds_d = blank_h ? 4'hF : bcd_h;
        tens_d     = blank_t ? 4'hF : bcd_t;
        ones_d     = bcd_o;
        unit_out_d = unit_cap_q;
        done_d     = 1'b1;
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dd_q       <= 20'd0;
      cnt_q      <= 3'd0;
      unit_cap_q <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      hundreds_q <= 4'd0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      unit_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dd_q       <= dd_d;
      cnt_q      <= cnt_d;
      unit_cap_q <= unit_cap_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      unit_out_q <= unit_out_d;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign unit_out = unit_out_q;

endmodule

// File: tb/tb_temp_bcd_formatter.sv
// Directed bench for temp_bcd_formatter: a blanking and a non-blanking instance share the stimulus.
// It uses a vector table plus hand-written sequences for ignored start, mid-conversion reset and input changes.
module tb_temp_bcd_formatter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin_in;
  logic       unit_in;
  logic       ready1, done1, unit_out1;
  logic [3:0] hundreds1, tens1, ones1;
  logic       ready0, done0, unit_out0;
  logic [3:0] hundreds0, tens0, ones0;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] bin;
    logic       unit;
    logic [3:0] h1;
    logic [3:0] t1;
    logic [3:0] h0;
    logic [3:0] t0;
    logic [3:0] o;
  } vec_t;

  vec_t vecs[10];

  temp_bcd_formatter #(.BLANK_LEADING(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .unit_in(unit_in),
    .ready(ready1), .done(done1), .hundreds(hundreds1), .tens(tens1), .ones(ones1),
    .unit_out(unit_out1)
  );

  temp_bcd_formatter #(.BLANK_LEADING(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .unit_in(unit_in),
    .ready(ready0), .done(done0), .hundreds(hundreds0), .tens(tens0), .ones(ones0),
    .unit_out(unit_out0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_done1"}, {31'd0, done1}, 0);
    chk({tag, "_ready1"}, {31'd0, ready1}, 1);
    chk({tag, "_digits1"}, {20'd0, hundreds1, tens1, ones1}, 0);
    chk({tag, "_unit1"}, {31'd0, unit_out1}, 0);
    chk({tag, "_digits0"}, {20'd0, hundreds0, tens0, ones0}, 0);
    chk({tag, "_ready0"}, {31'd0, ready0}, 1);
  endtask

  // Start one conversion; inputs are scrambled right after the capture edge.
  task automatic run_conv(input vec_t v);
    int   lat;
    logic rdy_bad;
    logic hold_bad;
    bin_in  = v.bin;
    unit_in = v.unit;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    bin_in  = ~v.bin;
    unit_in = ~v.unit;
    lat     = 0;
    rdy_bad = 1'b0;
    while (!done1 && lat < 20) begin
      if (ready1 || ready0 || done0) rdy_bad = 1'b1;
      tick();
      lat++;
    end
    chk($sformatf("latency_%0d", v.bin), lat, 9);
    chk($sformatf("ready_low_%0d", v.bin), {31'd0, rdy_bad}, 0);
    chk($sformatf("done0_%0d", v.bin), {31'd0, done0}, 1);
    chk($sformatf("digits1_%0d", v.bin), {20'd0, hundreds1, tens1, ones1}, {20'd0, v.h1, v.t1, v.o});
    chk($sformatf("digits0_%0d", v.bin), {20'd0, hundreds0, tens0, ones0}, {20'd0, v.h0, v.t0, v.o});
    chk($sformatf("unit_%0d", v.bin), {30'd0, unit_out1, unit_out0}, {30'd0, v.unit, v.unit});
    hold_bad = 1'b0;
    repeat (3) begin
      tick();
      if (done1 || done0 || !ready1 || !ready0) hold_bad = 1'b1;
      if ({hundreds1, tens1, ones1, unit_out1} !== {v.h1, v.t1, v.o, v.unit}) hold_bad = 1'b1;
      if ({hundreds0, tens0, ones0} !== {v.h0, v.t0, v.o}) hold_bad = 1'b1;
    end
    chk($sformatf("hold_%0d", v.bin), {31'd0, hold_bad}, 0);
  endtask

  initial begin
    int         pulses;
    logic [3:0] cap_h, cap_t, cap_o;
    logic       cap_u;
    logic       bad;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = 8'd0;
    unit_in  = 1'b0;

    //            bin     unit  h1     t1     h0     t0     o
    vecs[0] = '{8'd212, 1'b1, 4'd2,  4'd1,  4'd2,  4'd1,  4'd2};
    vecs[1] = '{8'd37,  1'b0, 4'hF,  4'd3,  4'd0,  4'd3,  4'd7};
    vecs[2] = '{8'd0,   1'b0, 4'hF,  4'hF,  4'd0,  4'd0,  4'd0};
    vecs[3] = '{8'd255, 1'b1, 4'd2,  4'd5,  4'd2,  4'd5,  4'd5};
    vecs[4] = '{8'd5,   1'b1, 4'hF,  4'hF,  4'd0,  4'd0,  4'd5};
    vecs[5] = '{8'd98,  1'b1, 4'hF,  4'd9,  4'd0,  4'd9,  4'd8};
    vecs[6] = '{8'd100, 1'b0, 4'd1,  4'd0,  4'd1,  4'd0,  4'd0};
    vecs[7] = '{8'd105, 1'b1, 4'd1,  4'd0,  4'd1,  4'd0,  4'd5};
    vecs[8] = '{8'd10,  1'b0, 4'hF,  4'd1,  4'd0,  4'd1,  4'd0};
    vecs[9] = '{8'd199, 1'b1, 4'd1,  4'd9,  4'd1,  4'd9,  4'd9};

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_conv(vecs[i]);

    // Second start at k+3 must be ignored.
    bin_in = 8'd150; unit_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    bin_in = 8'd99; unit_in = 1'b0; start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    cap_h = 4'd0; cap_t = 4'd0; cap_o = 4'd0; cap_u = 1'b0;
    for (int c = 4; c <= 24; c++) begin
      tick();
      if (done1) begin
        pulses++;
        cap_h = hundreds1; cap_t = tens1; cap_o = ones1; cap_u = unit_out1;
      end
    end
    chk("ignored_start_pulses", pulses, 1);
    chk("ignored_start_digits", {19'd0, cap_h, cap_t, cap_o, cap_u}, {19'd0, 4'd1, 4'd5, 4'd0, 1'b1});

    // Reset at k+4 aborts the conversion; start held during reset is ignored.
    bin_in = 8'd100; unit_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0; start = 1'b1; bin_in = 8'd77;
    tick();
    chk_reset_outputs("midreset");
    rst_n = 1'b1; start = 1'b0;
    bad = 1'b0;
    repeat (14) begin
      tick();
      if (done1 || done0 || !ready1) bad = 1'b1;
    end
    chk("midreset_no_done", {31'd0, bad}, 0);
    run_conv('{8'd123, 1'b1, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/temp_bcd_formatter.md
TEMP_BCD_FORMATTER -- requirements
Module: temp_bcd_formatter

Interface
REQ-001 SHALL have parameter BLANK_LEADING, default 1, which enables leading-zero blanking when 1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to convert bin_in; sampled only when ready=1.
REQ-005 SHALL have port bin_in, input, 8 bits: unsigned converted temperature from the upstream ROM conversion stage.
REQ-006 SHALL have port unit_in, input, 1 bit: unit tag for bin_in (1 = Fahrenheit result, 0 = Celsius result).
REQ-007 SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking new digit outputs.
REQ-009 SHALL have port hundreds, output, 4 bits: BCD hundreds digit, or 4'hF when blanked.
REQ-010 SHALL have port tens, output, 4 bits: BCD tens digit, or 4'hF when blanked.
REQ-011 SHALL have port ones, output, 4 bits: BCD ones digit; it is never blanked.
REQ-012 SHALL have port unit_out, output, 1 bit: unit_in captured with the conversion and presented with the digits.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE; ready SHALL be 1 exactly when state=IDLE.
REQ-014 In IDLE with start=1 at edge k, SHALL capture bin_in and unit_in, clear the 12-bit BCD accumulator, clear the 3-bit shift counter, and enter SHIFT.
REQ-015 In IDLE with start=0, SHALL remain in IDLE with all outputs held.
REQ-016 In SHIFT, each edge SHALL add 3 to every BCD nibble >=5, then shift the {BCD, binary} register left by one bit (double dabble).
REQ-017 SHALL perform exactly 8 shifts, on edges k+1..k+8; on the edge where the counter equals 7, it SHALL enter DONE.
REQ-018 In DONE, at edge k+9, SHALL register hundreds, tens, ones and unit_out, drive done=1, and return to IDLE.
REQ-019 done SHALL be high for exactly the one cycle following edge k+9; latency from the start edge to done is 9 cycles, giving at most one conversion per 10 cycles.
REQ-020 start while state is SHIFT or DONE SHALL be ignored: no capture, no queuing, and the conversion in flight is unaffected.
REQ-021 Changes on bin_in or unit_in after the capture edge SHALL NOT affect the conversion in flight.
REQ-022 Digit outputs and unit_out SHALL hold their values between done pulses.
REQ-023 With BLANK_LEADING=1, hundreds=0 SHALL output 4'hF; if both hundreds and tens are 0, tens SHALL output 4'hF.
REQ-024 With BLANK_LEADING=0, all digits SHALL be plain BCD.
REQ-025 Each digit SHALL always be 0-9 or 4'hF; for input 255 the digits SHALL be 2,5,5.

Reset
REQ-026 When rst_n=0 at a clock edge, state SHALL go to IDLE and done, hundreds, tens, ones and unit_out SHALL all be 0; ready SHALL therefore be 1.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no done pulse, and outputs SHALL take their reset values.
REQ-028 start sampled on an edge where rst_n=0 SHALL be ignored.

Verification
REQ-029 Bench SHALL cover: bin_in=212, unit_in=1, start at edge k -> at edge k+9, hundreds=2, tens=1, ones=2, unit_out=1, done=1 for one cycle; ready=0 from k to k+9.
REQ-030 Bench SHALL cover, with BLANK_LEADING=1: bin_in=37 -> F,3,7; bin_in=0 -> F,F,0; bin_in=255 -> 2,5,5.
REQ-031 Bench SHALL cover: BLANK_LEADING=0, bin_in=5 -> 0,0,5.
REQ-032 Bench SHALL cover: second start at k+3 with bin_in=99 -> ignored; first result only, and exactly one done pulse.
REQ-033 Bench SHALL cover: rst_n=0 at k+4 during conversion of 100 -> no done; outputs 0, ready=1; a new start then converts normally.
REQ-034 Bench SHALL cover: bin_in changed to 0 at k+1 after capture of 98 -> result F,9,8.
